ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the 8-bit RISC-V pipeline. Sits directly downstream of the decode stage and consumes its registered control, operand, immediate, funct and PC outputs.
- Performs ALU control decode, the 8-bit ALU operation and the branch target/condition evaluation.
- Registers all results into the EX/MEM pipeline register that feeds the memory stage.
- Supports pipeline stall (hold) and flush (bubble insertion).

Parameters:
PC_SIZE, 10, width of program counter / branch target in bits

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
stall  in  1  hold EX/MEM register contents
flush  in  1  insert bubble: clear control outputs next cycle
reg_write_in  in  1  decode-stage register write enable
branch_in  in  1  decode-stage branch flag
mem_read_in  in  1  decode-stage load flag
mem_to_reg_in  in  1  decode-stage writeback select
mem_write_in  in  1  decode-stage store flag
alu_op  in  2  ALU class from control unit
alu_src  in  1  1 = operand B is immediate
PC_in  in  PC_SIZE  PC of the instruction in EX
read_data1  in  8  rs1 value
read_data2  in  8  rs2 value
immediate  in  12  sign-extended-source immediate
funct  in  10  {funct7, funct3}
write_register_in  in  5  destination register index
reg_write_out  out  1  registered reg write enable
mem_read_out  out  1  registered load flag
mem_to_reg_out  out  1  registered writeback select
mem_write_out  out  1  registered store flag
branch_taken  out  1  registered: branch_in AND zero
branch_target  out  PC_SIZE  registered PC_in + (imm << 1)
alu_result  out  8  registered ALU result
zero  out  1  registered (alu_result == 0)
store_data  out  8  registered read_data2 (store data)
write_register_out  out  5  registered destination index

Behaviour:
- Latency: one cycle. Combinational decode/ALU feeds the EX/MEM register, which updates on the rising edge of clock.
- Priority per edge: reset > flush > stall > normal load.
- Reset: all outputs become 0, including branch_target, alu_result, zero and write_register_out.
- Flush:
  - reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out and branch_taken become 0.
  - Data outputs (alu_result, zero, branch_target, store_data, write_register_out) load normally.
  - Flush overrides a simultaneous stall.
- Stall: every output holds its previous value.
- Operand B = alu_src ? immediate[7:0] : read_data2. Operand A = read_data1.
- ALU control decode:
  - alu_op 00: ADD (load/store address).
  - alu_op 01: SUB (branch compare).
  - alu_op 10: R-type, decoded on the full funct value:
    - 0000000_000 ADD
    - 0100000_000 SUB
    - 0000000_111 AND
    - 0000000_110 OR
    - 0000000_100 XOR
    - 0000000_001 SLL
    - 0000000_101 SRL
    - 0000000_010 SLT
  - alu_op 11: I-type, decoded on funct[2:0] only: 000 ADD, 111 AND, 110 OR, 100 XOR, 010 SLT.
  - Any unlisted encoding gives result 8'h00.
- Arithmetic rules:
  - All arithmetic is modulo 256; carry-out and overflow are discarded.
  - Shift amount = B[2:0]; SRL is logical.
  - SLT compares A and B as signed 8-bit values; result is 8'h01 or 8'h00.
- zero is computed from the combinational ALU result and registered together with alu_result.
- branch_taken = branch_in & zero_comb, subject to flush and reset.
- Branch target:
  - branch_target = PC_in + {sign-extended immediate, 1'b0}, truncated to PC_SIZE bits.
  - Wrap-around is silent: PC_in = 1020 (PC_SIZE=10) with imm = 4 gives target 4.
- store_data is read_data2 regardless of alu_src.
- Bubble handling: a bubble arriving from decode (all control inputs 0) propagates as all-zero controls; no special case is required.

Test Plan:
- Reset: assert reset for 2 cycles with random inputs -> all outputs 0; release reset, alu_op=00, read_data1=8'h10, alu_src=1, immediate=12'h005 -> next cycle alu_result=8'h15, zero=0.
- R-type sweep, read_data1=8'hF0, read_data2=8'h0F, alu_op=10:
  - funct ADD -> 8'hFF
  - funct SUB -> 8'hE1
  - funct AND -> 8'h00 with zero=1
  - funct SLT -> 8'h01
  - funct SLL with read_data2=8'h09 -> 8'hE0
- Branch taken: branch_in=1, alu_op=01, read_data1=read_data2=8'h2A, PC_in=100, immediate=12'hFFC (-4) -> branch_taken=1, branch_target=92, zero=1. Repeat with read_data2=8'h2B -> branch_taken=0.
- Wrap and overflow: alu_op=00, read_data1=8'hFF, alu_src=1, immediate=12'h002 -> alu_result=8'h01; PC_in=1020, immediate=12'h004 -> branch_target=4.
- Stall/flush: load an add result 8'h33 with reg_write_in=1; assert stall while changing inputs -> outputs hold 8'h33 and reg_write_out=1; assert stall and flush together -> reg_write_out=0, mem_write_out=0, branch_taken=0, alu_result updates to the new value.
- Load/store path: mem_write_in=1, alu_op=00, read_data1=8'h40, immediate=12'h008, read_data2=8'h99, write_register_in=5'd7 -> alu_result=8'h48, store_data=8'h99, mem_write_out=1, write_register_out=7.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage of the 8-bit RISC-V pipeline: ALU control decode, 8-bit ALU,
// branch target/condition, and the EX/MEM pipeline register with stall/flush.
module ex_stage #(
  parameter int PC_SIZE = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               reg_write_in,
  input  logic               branch_in,
  input  logic               mem_read_in,
  input  logic               mem_to_reg_in,
  input  logic               mem_write_in,
  input  logic [1:0]         alu_op,
  input  logic               alu_src,
  input  logic [PC_SIZE-1:0] PC_in,
  input  logic [7:0]         read_data1,
  input  logic [7:0]         read_data2,
  input  logic [11:0]        immediate,
  input  logic [9:0]         funct,
  input  logic [4:0]         write_register_in,
  output logic               reg_write_out,
  output logic               mem_read_out,
  output logic               mem_to_reg_out,
  output logic               mem_write_out,
  output logic               branch_taken,
  output logic [PC_SIZE-1:0] branch_target,
  output logic [7:0]         alu_result,
  output logic               zero,
  output logic [7:0]         store_data,
  output logic [4:0]         write_register_out
);

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SLT, OP_NONE
  } alu_ctrl_t;

  localparam int EXT_W = PC_SIZE + 13;

  alu_ctrl_t         alu_ctrl_s;
  logic [7:0]        operand_a_s;
  logic [7:0]        operand_b_s;
  logic [7:0]        alu_result_s;
  logic              zero_s;
  logic [EXT_W-1:0]  pc_ext_s;
  logic [EXT_W-1:0]  offset_ext_s;
  logic [EXT_W-1:0]  target_ext_s;

  assign operand_a_s = read_data1;
  assign operand_b_s = alu_src ? immediate[7:0] : read_data2;

  // ALU control decode; R-type uses the full funct, I-type only funct3
  always_comb begin
    alu_ctrl_s = OP_NONE;
    case (alu_op)
      2'b00: alu_ctrl_s = OP_ADD;
      2'b01: alu_ctrl_s = OP_SUB;
      2'b10: begin
        case (funct)
          10'b0000000_000: alu_ctrl_s = OP_ADD;
          10'b0100000_000: alu_ctrl_s = OP_SUB;
          10'b0000000_111: alu_ctrl_s = OP_AND;
          10'b0000000_110: alu_ctrl_s = OP_OR;
          10'b0000000_100: alu_ctrl_s = OP_XOR;
          10'b0000000_001: alu_ctrl_s = OP_SLL;
          10'b0000000_101: alu_ctrl_s = OP_SRL;
          10'b0000000_010: alu_ctrl_s = OP_SLT;
          default:         alu_ctrl_s = OP_NONE;
        endcase
      end
      2'b11: begin
        case (funct[2:0])
          3'b000:  alu_ctrl_s = OP_ADD;
          3'b111:  alu_ctrl_s = OP_AND;
          3'b110:  alu_ctrl_s = OP_OR;
          3'b100:  alu_ctrl_s = OP_XOR;
          3'b010:  alu_ctrl_s = OP_SLT;
          default: alu_ctrl_s = OP_NONE;
        endcase
      end
      default: alu_ctrl_s = OP_NONE;
    endcase
  end

  // 8-bit ALU; arithmetic wraps modulo 256, shifts use B[2:0]
  always_comb begin
    alu_result_s = 8'h00;
    case (alu_ctrl_s)
      OP_ADD:  alu_result_s = operand_a_s + operand_b_s;
      OP_SUB:  alu_result_s = operand_a_s - operand_b_s;
      OP_AND:  alu_result_s = operand_a_s & operand_b_s;
      OP_OR:   alu_result_s = operand_a_s | operand_b_s;
      OP_XOR:  alu_result_s = operand_a_s ^ operand_b_s;
      OP_SLL:  alu_result_s = operand_a_s << operand_b_s[2:0];
      OP_SRL:  alu_result_s = operand_a_s >> operand_b_s[2:0];
      OP_SLT:  alu_result_s = ($signed(operand_a_s) < $signed(operand_b_s)) ? 8'h01 : 8'h00;
      default: alu_result_s = 8'h00;
    endcase
  end

  assign zero_s = (alu_result_s == 8'h00);

  // Target arithmetic is done wide and truncated so wrap-around is silent
  assign pc_ext_s     = {{13{1'b0}}, PC_in};
  assign offset_ext_s = {{PC_SIZE{immediate[11]}}, immediate, 1'b0};
  assign target_ext_s = pc_ext_s + offset_ext_s;

  // EX/MEM pipeline register: reset > flush > stall > load
  always_ff @(posedge clock) begin
    if (reset) begin
      reg_write_out      <= 1'b0;
      mem_read_out       <= 1'b0;
      mem_to_reg_out     <= 1'b0;
      mem_write_out      <= 1'b0;
      branch_taken       <= 1'b0;
      branch_target      <= {PC_SIZE{1'b0}};
      alu_result         <= 8'h00;
      zero               <= 1'b0;
      store_data         <= 8'h00;
      write_register_out <= 5'd0;
    end else if (flush || !stall) begin
      // A flush turns the controls into a bubble but still loads the data path
      reg_write_out      <= reg_write_in  & ~flush;
      mem_read_out       <= mem_read_in   & ~flush;
      mem_to_reg_out     <= mem_to_reg_in & ~flush;
      mem_write_out      <= mem_write_in  & ~flush;
      branch_taken       <= branch_in & zero_s & ~flush;
      branch_target      <= target_ext_s[PC_SIZE-1:0];
      alu_result         <= alu_result_s;
      zero               <= zero_s;
      store_data         <= read_data2;
      write_register_out <= write_register_in;
    end else begin
      reg_write_out      <= reg_write_out;
      mem_read_out       <= mem_read_out;
      mem_to_reg_out     <= mem_to_reg_out;
      mem_write_out      <= mem_write_out;
      branch_taken       <= branch_taken;
      branch_target      <= branch_target;
      alu_result         <= alu_result;
      zero               <= zero;
      store_data         <= store_data;
      write_register_out <= write_register_out;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed steps plus randomized traffic
// checked against an arithmetic reference model of the execute stage.
module tb_ex_stage;
  localparam int PC_SIZE = 10;
  localparam int PC_MOD  = 1 << PC_SIZE;

  logic clock = 1'b0;
  logic reset, stall, flush;
  logic reg_write_in, branch_in, mem_read_in, mem_to_reg_in, mem_write_in;
  logic [1:0] alu_op;
  logic alu_src;
  logic [PC_SIZE-1:0] PC_in;
  logic [7:0] read_data1, read_data2;
  logic [11:0] immediate;
  logic [9:0] funct;
  logic [4:0] write_register_in;
  logic reg_write_out, mem_read_out, mem_to_reg_out, mem_write_out, branch_taken, zero;
  logic [PC_SIZE-1:0] branch_target;
  logic [7:0] alu_result, store_data;
  logic [4:0] write_register_out;

  int total = 0;
  int bad   = 0;

  // expected register contents
  int e_rw, e_mr, e_mtr, e_mw, e_bt, e_tgt, e_res, e_zero, e_sd, e_wr;

  ex_stage #(.PC_SIZE(PC_SIZE)) dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .reg_write_in(reg_write_in), .branch_in(branch_in), .mem_read_in(mem_read_in),
    .mem_to_reg_in(mem_to_reg_in), .mem_write_in(mem_write_in), .alu_op(alu_op),
    .alu_src(alu_src), .PC_in(PC_in), .read_data1(read_data1), .read_data2(read_data2),
    .immediate(immediate), .funct(funct), .write_register_in(write_register_in),
    .reg_write_out(reg_write_out), .mem_read_out(mem_read_out),
    .mem_to_reg_out(mem_to_reg_out), .mem_write_out(mem_write_out),
    .branch_taken(branch_taken), .branch_target(branch_target), .alu_result(alu_result),
    .zero(zero), .store_data(store_data), .write_register_out(write_register_out)
  );

  always #5 clock = ~clock;

  function automatic int to_signed8(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  // Reference ALU from the instruction table, plain integer arithmetic
  function automatic int ref_alu(input int op, input int f, input int a, input int b);
    int f3 = f % 8;
    int sh = b % 8;
    string name = "none";
    if (op == 0) name = "add";
    else if (op == 1) name = "sub";
    else if (op == 2) begin
      if (f == 'h000) name = "add";
      else if (f == 'h100) name = "sub";
      else if (f == 'h007) name = "and";
      else if (f == 'h006) name = "or";
      else if (f == 'h004) name = "xor";
      else if (f == 'h001) name = "sll";
      else if (f == 'h005) name = "srl";
      else if (f == 'h002) name = "slt";
    end else begin
      if (f3 == 0) name = "add";
      else if (f3 == 7) name = "and";
      else if (f3 == 6) name = "or";
      else if (f3 == 4) name = "xor";
      else if (f3 == 2) name = "slt";
    end
    case (name)
      "add":   return (a + b) % 256;
      "sub":   return (a - b + 256) % 256;
      "and":   return a & b;
      "or":    return a | b;
      "xor":   return a ^ b;
      "sll":   return (a * (1 << sh)) % 256;
      "srl":   return a / (1 << sh);
      "slt":   return (to_signed8(a) < to_signed8(b)) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  // Advance the model by one clock edge using the currently driven inputs
  task automatic model_edge();
    int b, res, simm;
    b    = alu_src ? int'(immediate[7:0]) : int'(read_data2);
    res  = ref_alu(int'(alu_op), int'(funct), int'(read_data1), b);
    simm = (immediate >= 12'd2048) ? int'(immediate) - 4096 : int'(immediate);
    if (reset) begin
      {e_rw, e_mr, e_mtr, e_mw, e_bt, e_tgt, e_res, e_zero, e_sd, e_wr} = '0;
      e_rw = 0; e_mr = 0; e_mtr = 0; e_mw = 0; e_bt = 0;
      e_tgt = 0; e_res = 0; e_zero = 0; e_sd = 0; e_wr = 0;
    end else if (flush || !stall) begin
      e_rw   = flush ? 0 : int'(reg_write_in);
      e_mr   = flush ? 0 : int'(mem_read_in);
      e_mtr  = flush ? 0 : int'(mem_to_reg_in);
      e_mw   = flush ? 0 : int'(mem_write_in);
      e_bt   = (!flush && branch_in && res == 0) ? 1 : 0;
      e_tgt  = ((int'(PC_in) + 2 * simm) % PC_MOD + PC_MOD) % PC_MOD;
      e_res  = res;
      e_zero = (res == 0) ? 1 : 0;
      e_sd   = int'(read_data2);
      e_wr   = int'(write_register_in);
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".reg_write"},  int'(reg_write_out),      e_rw);
    chk({tag, ".mem_read"},   int'(mem_read_out),       e_mr);
    chk({tag, ".mem_to_reg"}, int'(mem_to_reg_out),     e_mtr);
    chk({tag, ".mem_write"},  int'(mem_write_out),      e_mw);
    chk({tag, ".taken"},      int'(branch_taken),       e_bt);
    chk({tag, ".target"},     int'(branch_target),      e_tgt);
    chk({tag, ".result"},     int'(alu_result),         e_res);
    chk({tag, ".zero"},       int'(zero),               e_zero);
    chk({tag, ".store"},      int'(store_data),         e_sd);
    chk({tag, ".wreg"},       int'(write_register_out), e_wr);
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clock);
    #1;
    check_all(tag);
  endtask

  task automatic randomize_inputs();
    logic [9:0] valid_funct [8];
    valid_funct = '{10'h000, 10'h100, 10'h007, 10'h006, 10'h004, 10'h001, 10'h005, 10'h002};
    reg_write_in  = 1'($urandom);
    branch_in     = 1'($urandom);
    mem_read_in   = 1'($urandom);
    mem_to_reg_in = 1'($urandom);
    mem_write_in  = 1'($urandom);
    alu_op        = 2'($urandom);
    alu_src       = 1'($urandom);
    PC_in         = PC_SIZE'($urandom);
    read_data1    = 8'($urandom);
    read_data2    = ($urandom_range(0, 3) == 0) ? read_data1 : 8'($urandom);
    immediate     = 12'($urandom);
    funct         = ($urandom_range(0, 3) == 0) ? 10'($urandom) : valid_funct[$urandom_range(0, 7)];
    write_register_in = 5'($urandom);
  endtask

  task automatic clear_ctl();
    {reg_write_in, branch_in, mem_read_in, mem_to_reg_in, mem_write_in} = 5'b0;
    {alu_src, stall, flush} = 3'b0;
    alu_op = 2'b00; PC_in = '0; read_data1 = 8'h00; read_data2 = 8'h00;
    immediate = 12'h000; funct = 10'h000; write_register_in = 5'd0;
  endtask

  initial begin
    clear_ctl();
    reset = 1'b1;
    e_rw = 0; e_mr = 0; e_mtr = 0; e_mw = 0; e_bt = 0;
    e_tgt = 0; e_res = 0; e_zero = 0; e_sd = 0; e_wr = 0;
    #1;
    // reset held two cycles under random inputs
    randomize_inputs(); step("reset1");
    randomize_inputs(); step("reset2");
    clear_ctl(); reset = 1'b0;
    alu_op = 2'b00; read_data1 = 8'h10; alu_src = 1'b1; immediate = 12'h005;
    step("first_add");
    chk("first_add.lit", int'(alu_result), 'h15);

    // R-type sweep
    clear_ctl(); alu_op = 2'b10; read_data1 = 8'hF0; read_data2 = 8'h0F;
    funct = 10'h000; step("r_add"); chk("r_add.lit", int'(alu_result), 'hFF);
    funct = 10'h100; step("r_sub"); chk("r_sub.lit", int'(alu_result), 'hE1);
    funct = 10'h007; step("r_and"); chk("r_and.zero", int'(zero), 1);
    funct = 10'h002; step("r_slt"); chk("r_slt.lit", int'(alu_result), 'h01);
    funct = 10'h001; read_data2 = 8'h09; step("r_sll"); chk("r_sll.lit", int'(alu_result), 'hE0);

    // branch taken / not taken
    clear_ctl(); branch_in = 1'b1; alu_op = 2'b01; read_data1 = 8'h2A; read_data2 = 8'h2A;
    PC_in = 10'd100; immediate = 12'hFFC;
    step("br_taken");
    chk("br_taken.lit", int'(branch_taken), 1);
    chk("br_target.lit", int'(branch_target), 92);
    read_data2 = 8'h2B; step("br_not"); chk("br_not.lit", int'(branch_taken), 0);

    // wrap-around on data and PC
    clear_ctl(); read_data1 = 8'hFF; alu_src = 1'b1; immediate = 12'h002;
    step("wrap_add"); chk("wrap_add.lit", int'(alu_result), 'h01);
    PC_in = 10'd1020; immediate = 12'h004;
    step("wrap_pc"); chk("wrap_pc.lit", int'(branch_target), 4);

    // stall holds, flush overrides stall
    clear_ctl(); reg_write_in = 1'b1; mem_write_in = 1'b1; read_data1 = 8'h30; alu_src = 1'b1; immediate = 12'h003;
    step("sf_load"); chk("sf_load.lit", int'(alu_result), 'h33);
    stall = 1'b1; read_data1 = 8'h50; write_register_in = 5'd3;
    step("sf_stall");
    chk("sf_stall.lit", int'(alu_result), 'h33);
    chk("sf_stall.rw", int'(reg_write_out), 1);
    flush = 1'b1; branch_in = 1'b1;
    step("sf_flush");
    chk("sf_flush.rw", int'(reg_write_out), 0);
    chk("sf_flush.lit", int'(alu_result), 'h53);

    // load/store path
    clear_ctl(); mem_write_in = 1'b1; read_data1 = 8'h40; alu_src = 1'b1; immediate = 12'h008;
    read_data2 = 8'h99; write_register_in = 5'd7;
    step("ls");
    chk("ls.res", int'(alu_result), 'h48);
    chk("ls.sd", int'(store_data), 'h99);
    chk("ls.mw", int'(mem_write_out), 1);
    chk("ls.wr", int'(write_register_out), 7);

    // randomized traffic with occasional stall, flush and reset
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 49) == 0);
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
